// File: rtl/life_cell_gen.sv
// rtl/life_cell_gen.sv - life-like cellular automaton cell with Generations decay, scan and age
module life_cell_gen #(
  parameter int NUM_STATES = 2,
  parameter int AGE_W = 8,
  localparam int STATE_W = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         nbr,
  input  logic [8:0]         birth_mask,
  input  logic [8:0]         survive_mask,
  input  logic               enb,
  input  logic               write,
  input  logic               val,
  input  logic               scan_en,
  input  logic               scan_in,
  output logic               scan_out,
  output logic [STATE_W-1:0] state,
  output logic               alive,
  output logic [AGE_W-1:0]   age,
  output logic               changed
);

  // States are compared in a 9-bit space so NUM_STATES up to 256 fits without wrap.
  localparam logic [8:0] LAST9 = 9'(NUM_STATES - 1);
  localparam logic [8:0] DYING_FIRST = (NUM_STATES == 2) ? 9'd0 : 9'd2;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [3:0]         count;
  logic [8:0]         cur9;
  logic [8:0]         nxt9;
  logic [STATE_W-1:0] state_next;
  logic [STATE_W-1:0] scan_next;

  assign cur9       = 9'(state);
  assign state_next = nxt9[STATE_W-1:0];
  assign alive      = (state == STATE_W'(1));
  assign scan_out   = state[STATE_W-1];

  // Scan shifts MSB out first; a one-bit state simply takes the scan input.
  generate
    if (STATE_W > 1) begin : g_scan_wide
      assign scan_next = {state[STATE_W-2:0], scan_in};
    end else begin : g_scan_narrow
      assign scan_next = scan_in;
    end
  endgenerate

  // Live-neighbour count, 0..8, used directly as the rule-mask index.
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, nbr[i]};
    end
  end

  // Rule evaluation: birth from dead, survive or start dying from alive,
  // dying states march to the last state then back to dead; illegal states go dead.
  always_comb begin
    nxt9 = 9'd0;
    if (cur9 == 9'd0) begin
      nxt9 = birth_mask[count] ? 9'd1 : 9'd0;
    end else if (cur9 == 9'd1) begin
      nxt9 = survive_mask[count] ? 9'd1 : DYING_FIRST;
    end else if (cur9 < LAST9) begin
      nxt9 = cur9 + 9'd1;
    end else begin
      nxt9 = 9'd0;
    end
  end

  // State, age and change flag; priority write > scan > step > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= '0;
      age     <= '0;
      changed <= 1'b0;
    end else if (write) begin
      state   <= val ? STATE_W'(1) : STATE_W'(0);
      age     <= '0;
      changed <= 1'b0;
    end else if (scan_en) begin
      state   <= scan_next;
      changed <= 1'b0;
    end else if (enb) begin
      state   <= state_next;
      changed <= (state_next != state);
      if ((cur9 == 9'd1) && (nxt9 == 9'd1)) begin
        age <= (age == AGE_MAX) ? age : age + AGE_W'(1);
      end else begin
        age <= '0;
      end
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_life_cell_gen.sv
// tb/tb_life_cell_gen.sv - self-checking bench for life_cell_gen
module tb_life_cell_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // two-state cell with a 2-bit age counter
  logic [7:0] nbr2;
  logic [8:0] bm2, sm2;
  logic enb2, wr2, val2, se2, si2;
  logic [0:0] st2;
  logic alive2, chg2, so2;
  logic [1:0] age2;

  // two chained four-state cells sharing control
  logic [7:0] nbr4;
  logic [8:0] bm4, sm4;
  logic enb4, wr4, val4, se4, si4;
  logic [1:0] st4a, st4b;
  logic alive4a, alive4b, chg4a, chg4b, so4a, so4b;
  logic [7:0] age4a, age4b;

  int m2s, m2a, m2c;
  int m4as, m4aa, m4ac;
  int m4bs, m4ba, m4bc;

  int bits[4] = '{1, 0, 1, 1};
  int outs[4] = '{1, 0, 1, 0};
  int age_seq[5] = '{1, 2, 3, 3, 3};
  int gen_st[4] = '{2, 3, 0, 0};
  int gen_chg[4] = '{1, 1, 1, 0};

  life_cell_gen #(.NUM_STATES(2), .AGE_W(2)) dut2 (
    .clk(clk), .reset(reset), .nbr(nbr2), .birth_mask(bm2), .survive_mask(sm2),
    .enb(enb2), .write(wr2), .val(val2), .scan_en(se2), .scan_in(si2),
    .scan_out(so2), .state(st2), .alive(alive2), .age(age2), .changed(chg2)
  );

  life_cell_gen #(.NUM_STATES(4), .AGE_W(8)) dut4a (
    .clk(clk), .reset(reset), .nbr(nbr4), .birth_mask(bm4), .survive_mask(sm4),
    .enb(enb4), .write(wr4), .val(val4), .scan_en(se4), .scan_in(si4),
    .scan_out(so4a), .state(st4a), .alive(alive4a), .age(age4a), .changed(chg4a)
  );

  life_cell_gen #(.NUM_STATES(4), .AGE_W(8)) dut4b (
    .clk(clk), .reset(reset), .nbr(nbr4), .birth_mask(bm4), .survive_mask(sm4),
    .enb(enb4), .write(wr4), .val(val4), .scan_en(se4), .scan_in(so4a),
    .scan_out(so4b), .state(st4b), .alive(alive4b), .age(age4b), .changed(chg4b)
  );

  function automatic int rule(input int s, input int c, input int ns,
                              input logic [8:0] bm, input logic [8:0] sm);
    if (s == 0) return bm[c] ? 1 : 0;
    if (s == 1) return sm[c] ? 1 : ((ns == 2) ? 0 : 2);
    if (s < ns - 1) return s + 1;
    return 0;
  endfunction

  task automatic mstep(input int ns, input int amax, input int wmask,
                       input bit wr, input bit v, input bit se, input bit si, input bit en,
                       input logic [7:0] nb, input logic [8:0] bm, input logic [8:0] sm,
                       inout int s, inout int a, inout int ch);
    int n;
    if (wr) begin
      s = v; a = 0; ch = 0;
    end else if (se) begin
      s = ((s << 1) | si) & wmask; ch = 0;
    end else if (en) begin
      n  = rule(s, $countones(nb), ns, bm, sm);
      a  = (s == 1 && n == 1) ? ((a < amax) ? a + 1 : amax) : 0;
      ch = (n != s) ? 1 : 0;
      s  = n;
    end else begin
      ch = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("c2_state", 32'(st2), 32'(m2s));
    chk("c2_alive", 32'(alive2), 32'(m2s == 1));
    chk("c2_age", 32'(age2), 32'(m2a));
    chk("c2_changed", 32'(chg2), 32'(m2c));
    chk("c2_scan_out", 32'(so2), 32'(m2s & 1));
    chk("c4a_state", 32'(st4a), 32'(m4as));
    chk("c4a_alive", 32'(alive4a), 32'(m4as == 1));
    chk("c4a_age", 32'(age4a), 32'(m4aa));
    chk("c4a_changed", 32'(chg4a), 32'(m4ac));
    chk("c4a_scan_out", 32'(so4a), 32'((m4as >> 1) & 1));
    chk("c4b_state", 32'(st4b), 32'(m4bs));
    chk("c4b_alive", 32'(alive4b), 32'(m4bs == 1));
    chk("c4b_age", 32'(age4b), 32'(m4ba));
    chk("c4b_changed", 32'(chg4b), 32'(m4bc));
    chk("c4b_scan_out", 32'(so4b), 32'((m4bs >> 1) & 1));
  endtask

  task automatic cyc();
    int sb;
    @(posedge clk);
    sb = (m4as >> 1) & 1;
    mstep(2, 3, 1, wr2, val2, se2, si2, enb2, nbr2, bm2, sm2, m2s, m2a, m2c);
    mstep(4, 255, 3, wr4, val4, se4, si4, enb4, nbr4, bm4, sm4, m4as, m4aa, m4ac);
    mstep(4, 255, 3, wr4, val4, se4, sb[0], enb4, nbr4, bm4, sm4, m4bs, m4ba, m4bc);
    #1;
    check_all();
  endtask

  task automatic idle();
    wr2 = 0; se2 = 0; enb2 = 0; si2 = 0; val2 = 0;
    wr4 = 0; se4 = 0; enb4 = 0; si4 = 0; val4 = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    nbr2 = 0; bm2 = 0; sm2 = 0; nbr4 = 0; bm4 = 0; sm4 = 0;
    m2s = 0; m2a = 0; m2c = 0;
    m4as = 0; m4aa = 0; m4ac = 0; m4bs = 0; m4ba = 0; m4bc = 0;
    #12;
    check_all();
    reset = 1'b0;

    // B3/S23 basic behaviour
    bm2 = 9'h008; sm2 = 9'h00C;
    wr2 = 1; val2 = 1; cyc(); wr2 = 0;
    enb2 = 1; nbr2 = 8'b0000_0111; cyc();
    chk("t1_state_survive", 32'(st2), 1);
    chk("t1_changed_0", 32'(chg2), 0);
    chk("t1_age_1", 32'(age2), 1);
    nbr2 = 8'b0000_0001; cyc();
    chk("t1_state_die", 32'(st2), 0);
    chk("t1_changed_1", 32'(chg2), 1);
    chk("t1_age_0", 32'(age2), 0);
    idle();

    // Generations B2/S- on four-state cells
    bm4 = 9'h004; sm4 = 9'h000;
    wr4 = 1; val4 = 0; cyc(); wr4 = 0;
    enb4 = 1; nbr4 = 8'b0001_0001; cyc();
    chk("t2_born", 32'(st4a), 1);
    chk("t2_alive", 32'(alive4a), 1);
    chk("t2_chg", 32'(chg4a), 1);
    nbr4 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_decay_state", 32'(st4a), 32'(gen_st[i]));
      chk("t2_decay_alive", 32'(alive4a), 0);
      chk("t2_decay_chg", 32'(chg4a), 32'(gen_chg[i]));
    end
    idle();

    // priority write > scan > step
    wr2 = 1; val2 = 1; cyc();
    wr2 = 1; val2 = 0; se2 = 1; enb2 = 1; si2 = 1; nbr2 = 8'b0000_0111; cyc();
    chk("t3_write_state", 32'(st2), 0);
    chk("t3_write_age", 32'(age2), 0);
    chk("t3_write_chg", 32'(chg2), 0);
    wr2 = 0; si2 = 0; cyc();
    chk("t3_scan_over_step", 32'(st2), 0);
    si2 = 1; cyc();
    chk("t3_scan_in_1", 32'(st2), 1);
    chk("t3_scan_chg", 32'(chg2), 0);
    idle();

    // scan chain through two 2-bit cells
    wr4 = 1; val4 = 1; cyc(); wr4 = 0;
    enb4 = 1; sm4 = 9'h000; nbr4 = 8'h00; cyc(); enb4 = 0;
    se4 = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_scan_out", 32'(so4b), 32'(outs[i]));
      si4 = bits[i][0];
      cyc();
    end
    se4 = 0;
    chk("t4_first_cell", 32'(st4a), 3);
    chk("t4_second_cell", 32'(st4b), 2);
    enb4 = 1; cyc();
    chk("t4_last_to_dead", 32'(st4a), 0);
    chk("t4_dying_adv", 32'(st4b), 3);
    idle();

    // saturating age with AGE_W=2
    bm2 = 9'h008; sm2 = 9'h00C;
    wr2 = 1; val2 = 1; cyc(); wr2 = 0;
    enb2 = 1; nbr2 = 8'b0000_0011;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_age", 32'(age2), 32'(age_seq[i]));
    end
    nbr2 = 8'h00; cyc();
    chk("t5_death", 32'(st2), 0);
    nbr2 = 8'b0000_0111; cyc();
    chk("t5_birth_state", 32'(st2), 1);
    chk("t5_birth_age", 32'(age2), 0);
    idle();

    // asynchronous reset between edges
    wr2 = 1; val2 = 1; cyc(); wr2 = 0;
    enb2 = 1; nbr2 = 8'b0000_0011;
    repeat (3) cyc();
    chk("t6_age_before", 32'(age2), 3);
    #2;
    reset = 1'b1;
    m2s = 0; m2a = 0; m2c = 0;
    m4as = 0; m4aa = 0; m4ac = 0; m4bs = 0; m4ba = 0; m4bc = 0;
    #1;
    chk("t6_rst_state", 32'(st2), 0);
    chk("t6_rst_age", 32'(age2), 0);
    chk("t6_rst_alive", 32'(alive2), 0);
    chk("t6_rst_chg", 32'(chg2), 0);
    chk("t6_rst_scan_out", 32'(so2), 0);
    check_all();
    #1;
    reset = 1'b0;
    nbr2 = 8'b0000_0111; cyc();
    chk("t6_post_reset_birth", 32'(st2), 1);
    idle();

    // randomized operation mix against the model
    repeat (400) begin
      wr2 = ($urandom_range(7) == 0); se2 = ($urandom_range(3) == 0);
      enb2 = 1'($urandom_range(1)); val2 = 1'($urandom_range(1)); si2 = 1'($urandom_range(1));
      nbr2 = 8'($urandom); bm2 = 9'($urandom); sm2 = 9'($urandom);
      wr4 = ($urandom_range(7) == 0); se4 = ($urandom_range(3) == 0);
      enb4 = 1'($urandom_range(1)); val4 = 1'($urandom_range(1)); si4 = 1'($urandom_range(1));
      nbr4 = 8'($urandom); bm4 = 9'($urandom); sm4 = 9'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/life_cell_gen.md
Name: life_cell_gen

Overview:
Parametrised next-generation cellular-automaton cell for the life array. It supports any outer-totalistic "life-like" rule through run-time birth/survive masks, and optional multi-state "Generations" decay (dying states). It also provides a serial scan path for state load/readback, a saturating age counter and a per-step change flag. It is tiled in the array exactly like the basic cell, with neighbours wired to the eight `alive` outputs around it.

Parameters:
NUM_STATES, 2, total cell states (2 = classic two-state life; >2 adds dying states 2..NUM_STATES-1); legal range 2..256
STATE_W, $clog2(NUM_STATES) (min 1), width of state register; derived, not overridden
AGE_W, 8, width of saturating age counter

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; clears state, age, changed
nbr  input  8  alive bits of neighbours {nw,w,sw,s,se,e,ne,n}
birth_mask  input  9  bit c set = dead cell with c live neighbours is born
survive_mask  input  9  bit c set = live cell with c live neighbours survives
enb  input  1  advance one generation this cycle
write  input  1  direct load enable
val  input  1  load value (1 = alive, 0 = dead)
scan_en  input  1  shift state register one bit
scan_in  input  1  serial scan input
scan_out  output  1  serial scan output = state[STATE_W-1]
state  output  STATE_W  current cell state
alive  output  1  state == 1 (combinational from register)
age  output  AGE_W  consecutive generations alive, saturating
changed  output  1  registered; 1 for the cycle after a step that changed state

Behaviour:
- Reset (async): state=0, age=0, changed=0; hence alive=0 and scan_out=0. Deassertion is taken synchronously by the array-level reset synchroniser; the cell does not resynchronise it.
- Neighbour count c = popcount(nbr), 4 bits, range 0..8. It indexes the masks directly.
- Per-edge priority: write > scan_en > enb > hold.
- write:
  - state <= val ? 1 : 0; age <= 0; changed <= 0.
- scan_en:
  - STATE_W>1: state <= {state[STATE_W-2:0], scan_in}, MSB out first. STATE_W==1: state <= scan_in.
  - age held; changed <= 0.
  - Chaining cells scan_out->scan_in gives an array-wide shift chain of length cells*STATE_W.
- enb step, next state:
  - state 0: birth_mask[c] ? 1 : 0.
  - state 1: survive_mask[c] ? 1 : (NUM_STATES==2 ? 0 : 2).
  - state k, 2 <= k <= NUM_STATES-2: k+1, independent of neighbours.
  - state NUM_STATES-1 (when >=2): 0.
  - state >= NUM_STATES (illegal, only reachable by scan): 0.
  - Dying states are not alive: they do not count as neighbours and cannot be reborn until they reach 0.
- age on enb step:
  - 1->1: age <= age+1, saturating at 2^AGE_W-1 (no wrap).
  - Any transition into 1 from another state: age <= 0.
  - Any next state other than 1: age <= 0.
- changed on enb step: changed <= (next_state != state). On every cycle that is not an enb step (including hold, write and scan): changed <= 0.
- Latency: one clock from enb to updated state/alive/age/changed. There is no combinational path from nbr to any output.
- With masks B3/S23 (birth_mask=9'h008, survive_mask=9'h00C) and NUM_STATES=2, behaviour is bit-identical to the basic cell for write/enb/hold.
- Reset asserted mid-step or mid-scan clears immediately, regardless of write/scan_en/enb. The first edge after release follows normal priority.

Test Plan:
- NUM_STATES=2, B3/S23; write val=1; enb with nbr=8'b0000_0111 (c=3) then nbr=8'b0000_0001 (c=1) -> state 1 then 0; changed 0 then 1; age 1 then 0.
- NUM_STATES=4, B2/S none (birth_mask=9'h004, survive_mask=0); dead cell with c=2, then 4 enb steps at c=0 -> state sequence 1,2,3,0,0; alive only in first; changed 1,1,1,1,0.
- Priority: write=1, val=0, scan_en=1, enb=1 on a live cell with c=3 -> state 0, age 0, changed 0. Then scan_en=1 with enb=1 -> shift occurs, no rule evaluation.
- NUM_STATES=4 (STATE_W=2): two cells chained, shift 4 bits 1,0,1,1 -> first cell (fed by the chain input) state 2'b11, second cell state 2'b10; scan_out sequence matches the prior contents MSB-first. A following enb on the state-3 cell -> 0.
- AGE_W=2, B3/S23, live cell held at c=2 for 5 enb steps -> age 1,2,3,3,3. Birth after death -> age 0.
- Assert reset asynchronously between edges while state=1 and age=3 -> state, age, alive, changed, scan_out all 0 before the next edge. Release, then enb at c=3 -> state 1.
